pulse_gen_mc: RTL and testbench
===============================

PULSE_GEN_MC -- requirements
Module: pulse_gen_mc

Interface
REQ-001 The block SHALL have parameter CH, default 4, number of independent pulse channels.
REQ-002 The block SHALL have parameter CNTR_WIDTH, default 16, period/threshold counter width.
REQ-003 The block SHALL have parameter BURST_WIDTH, default 8, burst-count width.
REQ-004 The block SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-005 The block SHALL have port nrst  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have port en  input  1  global enable; low freezes all channel state.
REQ-007 The block SHALL have port start  input  CH  per-channel start request, level-sampled.
REQ-008 The block SHALL have port stop  input  CH  per-channel graceful stop request.
REQ-009 The block SHALL have port cntr_max  input  CH*CNTR_WIDTH  per-channel period-1 value, channel i at slice i.
REQ-010 The block SHALL have port cntr_low  input  CH*CNTR_WIDTH  per-channel HIGH-to-LOW threshold.
REQ-011 The block SHALL have port burst_len  input  CH*BURST_WIDTH  periods per burst; 0 = continuous.
REQ-012 The block SHALL have port pulse_out  output  CH  active-HIGH pulse outputs.
REQ-013 The block SHALL have port start_strobe  output  CH  one-cycle strobe on accepted start.
REQ-014 The block SHALL have port done_strobe  output  CH  one-cycle strobe on burst completion.
REQ-015 The block SHALL have port busy  output  CH  channel not IDLE.

Function
REQ-016 Each channel SHALL run its own FSM: IDLE, PHASE (only with PULSE_GEN_MC_PHASE_EN), RUN; channels share no state.
REQ-017 In IDLE with en=1, start=1, stop=0 and cntr_max!=0, the channel SHALL accept: counter<=cntr_max, low_buf<=cntr_low, remaining<=burst_len, enter RUN.
REQ-018 start with cntr_max==0, start while busy, or start and stop in the same IDLE cycle SHALL be ignored without any strobe.
REQ-019 start_strobe SHALL be high for exactly the first cycle after acceptance.
REQ-020 In RUN the counter SHALL decrement by 1 per enabled cycle; period = cntr_max+1 cycles.
REQ-021 pulse_out SHALL equal (state==RUN && counter>=low_buf); cntr_low=0 gives constant HIGH, cntr_low>cntr_max gives constant LOW.
REQ-022 pulse_out SHALL be 0 in IDLE and PHASE.
REQ-023 At counter==0 in RUN the channel SHALL end the burst if (remaining==1) or stop seen or live cntr_max==0; otherwise it reloads counter and low_buf from live inputs and decrements remaining (non-zero only).
REQ-024 burst_len=0 SHALL run periods until stop; stop SHALL be latched and honoured only at the next period boundary (current period completes).
REQ-025 On burst end the channel SHALL enter IDLE; done_strobe SHALL be high for the first IDLE cycle, busy low in that cycle.
REQ-026 A start present in the done_strobe cycle SHALL be accepted (minimum one idle cycle between bursts).
REQ-027 With en=0, counters, FSM, latched stop SHALL hold; start_strobe/done_strobe SHALL be 0; pulse_out and busy SHALL reflect held state.

Reset
REQ-028 nrst=0 SHALL asynchronously force all channels to IDLE, counters/buffers/remaining to 0, all outputs to 0, without clk.
REQ-029 Reset mid-burst SHALL abort with no done_strobe; first start after release SHALL behave as from power-up.

Configuration
REQ-030 Macro PULSE_GEN_MC_PHASE_EN defined: input phase (CH*CNTR_WIDTH) added; accepted start with phase!=0 enters PHASE for exactly phase cycles (busy=1, pulse_out=0), then RUN; phase=0 goes directly to RUN; phase offset applies only to the first period.
REQ-031 Macro undefined: phase port and PHASE state SHALL not exist; accepted start enters RUN directly.

Verification
REQ-032 CNTR_WIDTH=8, ch0 cntr_max=4, cntr_low=2, burst_len=1, start 1 cycle -> start_strobe 1 cycle, pulse_out 1,1,1,0,0, busy 5 cycles, done_strobe on cycle 6.
REQ-033 cntr_max=3, cntr_low=1, burst_len=3, cntr_low changed to 3 during period 1 -> pulse_out 1110 then 1000,1000; busy exactly 12 cycles.
REQ-034 cntr_max=0 start -> no strobe, busy 0; cntr_max=5, cntr_low=7 -> pulse_out 0 for 6 cycles, busy 1.
REQ-035 burst_len=0, cntr_max=9, stop pulsed at counter=6 -> remaining 7 cycles of period complete, then done_strobe; ch1 running concurrently unaffected.
REQ-036 nrst low mid-RUN between clock edges -> pulse_out, busy, strobes 0 immediately; en low 5 cycles mid-period -> period stretched by exactly 5 cycles.
REQ-037 With PULSE_GEN_MC_PHASE_EN, phase=3, cntr_max=2, cntr_low=1 -> busy 1 with pulse_out 0 for 3 cycles, then 1,1,0.

Source files
------------

// File: rtl/pulse_gen_mc.sv
// pulse_gen_mc: CH independent burst pulse generators sharing only clock,
// reset and global enable. Each channel counts down from cntr_max, drives
// its pulse HIGH while the count is at or above a buffered threshold, and
// repeats for burst_len periods (0 = run until a graceful stop).
// Optional feature macro: PULSE_GEN_MC_PHASE_EN adds a per-channel phase
// input that delays the first period of a burst by 'phase' cycles.
module pulse_gen_mc #(
    parameter int CH          = 4,
    parameter int CNTR_WIDTH  = 16,
    parameter int BURST_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      en,
    input  logic [CH-1:0]             start,
    input  logic [CH-1:0]             stop,
    input  logic [CH*CNTR_WIDTH-1:0]  cntr_max,
    input  logic [CH*CNTR_WIDTH-1:0]  cntr_low,
    input  logic [CH*BURST_WIDTH-1:0] burst_len,
`ifdef PULSE_GEN_MC_PHASE_EN
    input  logic [CH*CNTR_WIDTH-1:0]  phase,
`endif
    output logic [CH-1:0]             pulse_out,
    output logic [CH-1:0]             start_strobe,
    output logic [CH-1:0]             done_strobe,
    output logic [CH-1:0]             busy
);

`ifdef PULSE_GEN_MC_PHASE_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PHASE = 2'd1,
        ST_RUN   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd2
    } state_t;
`endif

    localparam logic [CNTR_WIDTH-1:0]  CNTR_ONE  = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [BURST_WIDTH-1:0] BURST_ONE = {{(BURST_WIDTH-1){1'b0}}, 1'b1};

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_t                 state;
        logic [CNTR_WIDTH-1:0]  counter;
        logic [CNTR_WIDTH-1:0]  low_buf;
        logic [BURST_WIDTH-1:0] remaining;
        logic                   stop_latched;
        logic                   start_q;
        logic                   done_q;

        logic [CNTR_WIDTH-1:0]  max_i;
        logic [CNTR_WIDTH-1:0]  low_i;
        logic [BURST_WIDTH-1:0] burst_i;
        logic                   accept;
        logic                   last_period;

        assign max_i   = cntr_max[i*CNTR_WIDTH +: CNTR_WIDTH];
        assign low_i   = cntr_low[i*CNTR_WIDTH +: CNTR_WIDTH];
        assign burst_i = burst_len[i*BURST_WIDTH +: BURST_WIDTH];

        // A start is only taken from IDLE, without a simultaneous stop, and
        // only when the period would be longer than one cycle.
        assign accept = (state == ST_IDLE) && start[i] && !stop[i] && (max_i != '0);

        // Decided at the period boundary: burst count exhausted, a stop
        // pending (latched earlier or arriving now), or period set to zero.
        assign last_period = (remaining == BURST_ONE) || stop_latched || stop[i] || (max_i == '0);

`ifdef PULSE_GEN_MC_PHASE_EN
        logic [CNTR_WIDTH-1:0] phase_cnt;
        logic [CNTR_WIDTH-1:0] phase_i;

        assign phase_i = phase[i*CNTR_WIDTH +: CNTR_WIDTH];
`endif

        // Channel FSM: accept, optional phase delay, period countdown and
        // burst bookkeeping; the whole channel freezes while en is low.
        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                state        <= ST_IDLE;
                counter      <= '0;
                low_buf      <= '0;
                remaining    <= '0;
                stop_latched <= 1'b0;
                start_q      <= 1'b0;
                done_q       <= 1'b0;
`ifdef PULSE_GEN_MC_PHASE_EN
                phase_cnt    <= '0;
`endif
            end else if (!en) begin
                start_q <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                start_q <= 1'b0;
                done_q  <= 1'b0;
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            counter      <= max_i;
                            low_buf      <= low_i;
                            remaining    <= burst_i;
                            stop_latched <= 1'b0;
                            start_q      <= 1'b1;
`ifdef PULSE_GEN_MC_PHASE_EN
                            if (phase_i != '0) begin
                                state     <= ST_PHASE;
                                phase_cnt <= phase_i;
                            end else begin
                                state <= ST_RUN;
                            end
`else
                            state        <= ST_RUN;
`endif
                        end
                    end
`ifdef PULSE_GEN_MC_PHASE_EN
                    ST_PHASE: begin
                        if (stop[i]) begin
                            stop_latched <= 1'b1;
                        end
                        if (phase_cnt == CNTR_ONE) begin
                            state     <= ST_RUN;
                            phase_cnt <= '0;
                        end else begin
                            phase_cnt <= phase_cnt - CNTR_ONE;
                        end
                    end
`endif
                    ST_RUN: begin
                        if (counter == '0) begin
                            if (last_period) begin
                                state        <= ST_IDLE;
                                stop_latched <= 1'b0;
                                done_q       <= 1'b1;
                            end else begin
                                counter <= max_i;
                                low_buf <= low_i;
                                if (remaining != '0) begin
                                    remaining <= remaining - BURST_ONE;
                                end
                            end
                        end else begin
                            counter <= counter - CNTR_ONE;
                            if (stop[i]) begin
                                stop_latched <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end

        assign pulse_out[i]    = (state == ST_RUN) && (counter >= low_buf);
        assign busy[i]         = (state != ST_IDLE);
        assign start_strobe[i] = start_q;
        assign done_strobe[i]  = done_q;
    end

endmodule

// File: tb/tb_pulse_gen_mc.sv
// tb_pulse_gen_mc: self-checking bench for pulse_gen_mc (CH=4, 8-bit
// counters). Directed table, hand-written corner sequences and a random
// run compared every cycle against a period/elapsed-time reference model.
module tb_pulse_gen_mc;

    localparam int CH = 4;
    localparam int CW = 8;
    localparam int BW = 8;

    logic              clk;
    logic              nrst;
    logic              en;
    logic [CH-1:0]     start;
    logic [CH-1:0]     stop;
    logic [CH*CW-1:0]  cntr_max;
    logic [CH*CW-1:0]  cntr_low;
    logic [CH*BW-1:0]  burst_len;
`ifdef PULSE_GEN_MC_PHASE_EN
    logic [CH*CW-1:0]  phase;
`endif
    logic [CH-1:0]     pulse_out;
    logic [CH-1:0]     start_strobe;
    logic [CH-1:0]     done_strobe;
    logic [CH-1:0]     busy;

    int checks   = 0;
    int failures = 0;

    pulse_gen_mc #(
        .CH          (CH),
        .CNTR_WIDTH  (CW),
        .BURST_WIDTH (BW)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .en           (en),
        .start        (start),
        .stop         (stop),
        .cntr_max     (cntr_max),
        .cntr_low     (cntr_low),
        .burst_len    (burst_len),
`ifdef PULSE_GEN_MC_PHASE_EN
        .phase        (phase),
`endif
        .pulse_out    (pulse_out),
        .start_strobe (start_strobe),
        .done_strobe  (done_strobe),
        .busy         (busy)
    );

    // 10-unit clock, first rising edge at t=5
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each channel tracks cycles elapsed in the current
    // period, the period length, threshold, periods left and pending stop.
    bit m_active [CH];
    int m_elapsed[CH];
    int m_len    [CH];
    int m_low    [CH];
    int m_left   [CH];
    int m_phase  [CH];
    bit m_stop   [CH];
    bit m_ss     [CH];
    bit m_ds     [CH];

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_active[c] = 0; m_elapsed[c] = 0; m_len[c] = 1; m_low[c] = 0;
            m_left[c] = 0; m_phase[c] = 0; m_stop[c] = 0; m_ss[c] = 0; m_ds[c] = 0;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < CH; c++) begin
            int mx;
            int lo;
            mx = int'(cntr_max[c*CW +: CW]);
            lo = int'(cntr_low[c*CW +: CW]);
            m_ss[c] = 0;
            m_ds[c] = 0;
            if (!en) begin
                continue;
            end
            if (!m_active[c]) begin
                if (start[c] && !stop[c] && mx != 0) begin
                    m_active[c]  = 1;
                    m_elapsed[c] = 0;
                    m_len[c]     = mx + 1;
                    m_low[c]     = lo;
                    m_left[c]    = int'(burst_len[c*BW +: BW]);
                    m_stop[c]    = 0;
                    m_ss[c]      = 1;
`ifdef PULSE_GEN_MC_PHASE_EN
                    m_phase[c]   = int'(phase[c*CW +: CW]);
`else
                    m_phase[c]   = 0;
`endif
                end
            end else if (m_phase[c] > 0) begin
                m_phase[c]--;
                if (stop[c]) m_stop[c] = 1;
            end else if (m_elapsed[c] == m_len[c] - 1) begin
                if (m_left[c] == 1 || m_stop[c] || stop[c] || mx == 0) begin
                    m_active[c] = 0;
                    m_stop[c]   = 0;
                    m_ds[c]     = 1;
                end else begin
                    m_elapsed[c] = 0;
                    m_len[c]     = mx + 1;
                    m_low[c]     = lo;
                    if (m_left[c] > 0) m_left[c]--;
                end
            end else begin
                m_elapsed[c]++;
                if (stop[c]) m_stop[c] = 1;
            end
        end
    endtask

    task automatic model_expect(output logic [CH-1:0] ep, output logic [CH-1:0] es,
                                output logic [CH-1:0] ed, output logic [CH-1:0] eb);
        for (int c = 0; c < CH; c++) begin
            eb[c] = m_active[c];
            ep[c] = m_active[c] && (m_phase[c] == 0) && ((m_len[c] - 1 - m_elapsed[c]) >= m_low[c]);
            es[c] = m_ss[c];
            ed[c] = m_ds[c];
        end
    endtask

    task automatic checkOutput(input string name, input logic [CH-1:0] ep, input logic [CH-1:0] es,
                               input logic [CH-1:0] ed, input logic [CH-1:0] eb);
        checks++;
        if (pulse_out !== ep || start_strobe !== es || done_strobe !== ed || busy !== eb) begin
            failures++;
            $display("[TB] FAIL %s t=%0t: got pulse=%b ss=%b ds=%b busy=%b, want pulse=%b ss=%b ds=%b busy=%b",
                     name, $time, pulse_out, start_strobe, done_strobe, busy, ep, es, ed, eb);
        end
    endtask

    task automatic check_val(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    // One clock cycle: drive inputs, advance the model at the edge and
    // compare all outputs just after it.
    task automatic applyStimulus(input logic e, input logic [CH-1:0] s, input logic [CH-1:0] sp);
        logic [CH-1:0] ep, es, ed, eb;
        en    = e;
        start = s;
        stop  = sp;
        @(posedge clk);
        model_step();
        #1;
        model_expect(ep, es, ed, eb);
        checkOutput("model", ep, es, ed, eb);
    endtask

    task automatic set_cfg(input int c, input int mx, input int lo, input int bl);
        cntr_max[c*CW +: CW]  = CW'(mx);
        cntr_low[c*CW +: CW]  = CW'(lo);
        burst_len[c*BW +: BW] = BW'(bl);
    endtask

    task automatic clear_cfg();
        for (int c = 0; c < CH; c++) set_cfg(c, 0, 0, 0);
    endtask

    typedef struct {
        logic       en;
        logic       st;
        logic       sp;
        logic [7:0] mx;
        logic [7:0] lo;
        logic [7:0] bl;
        logic       ep;
        logic       es;
        logic       ed;
        logic       eb;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int bc;
        int ds_at;
        int ss_cnt;
        int ds_cnt;
        logic [11:0] pat;

        // Basic single-period burst, then ignored zero-period start and an
        // always-LOW channel whose threshold exceeds the period.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'd4, 8'd2, 8'd1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'd4, 8'd2, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'd4, 8'd2, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'd4, 8'd2, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'd4, 8'd2, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'd4, 8'd2, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'd4, 8'd2, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'd5, 8'd7, 8'd1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'd5, 8'd7, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 8'd5, 8'd7, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 8'd5, 8'd7, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 8'd5, 8'd7, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 8'd5, 8'd7, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 8'd5, 8'd7, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0};

        nrst  = 1'b0;
        en    = 1'b0;
        start = '0;
        stop  = '0;
        clear_cfg();
`ifdef PULSE_GEN_MC_PHASE_EN
        phase = '0;
`endif
        model_reset();

        // Reset state
        #12;
        checkOutput("reset_state", '0, '0, '0, '0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven directed vectors on channel 0
        for (int i = 0; i < 15; i++) begin
            set_cfg(0, int'(tbl[i].mx), int'(tbl[i].lo), int'(tbl[i].bl));
            applyStimulus(tbl[i].en, {3'b000, tbl[i].st}, {3'b000, tbl[i].sp});
            checkOutput("table", {3'b000, tbl[i].ep}, {3'b000, tbl[i].es},
                        {3'b000, tbl[i].ed}, {3'b000, tbl[i].eb});
        end
        clear_cfg();

        // Three-period burst with threshold raised during the first period
        set_cfg(0, 3, 1, 3);
        bc = 0;
        pat = '0;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, (k == 0) ? 4'b0001 : 4'b0000, 4'b0000);
            if (k == 0) set_cfg(0, 3, 3, 3);
            if (k < 12) pat[11-k] = pulse_out[0];
            if (busy[0]) bc++;
        end
        check_val("burst3_pattern", int'(pat), int'(12'b1110_1000_1000));
        check_val("burst3_busy_cycles", bc, 12);
        clear_cfg();

        // Continuous channel 0 stopped at counter 6; channel 1 runs alongside
        set_cfg(0, 9, 5, 0);
        set_cfg(1, 3, 2, 0);
        bc = 0;
        ds_at = -1;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b1, (k == 0) ? 4'b0011 : 4'b0000, (k == 4) ? 4'b0001 : 4'b0000);
            if (busy[0]) bc++;
            if (done_strobe[0] && ds_at < 0) ds_at = k;
        end
        check_val("stop_busy_cycles", bc, 10);
        check_val("stop_done_cycle", ds_at, 10);
        check_val("stop_other_channel_busy", int'(busy[1]), 1);
        for (int k = 0; k < 8; k++) applyStimulus(1'b1, 4'b0000, 4'b0010);
        check_val("stop_ch1_idle", int'(busy[1]), 0);
        clear_cfg();

        // Start held high: re-accepted in each done_strobe cycle
        set_cfg(2, 1, 0, 1);
        ss_cnt = 0;
        ds_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 4'b0100, 4'b0000);
            if (start_strobe[2]) ss_cnt++;
            if (done_strobe[2]) ds_cnt++;
        end
        check_val("backtoback_starts", ss_cnt, 3);
        check_val("backtoback_dones", ds_cnt, 2);
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 4'b0000, 4'b0000);
        clear_cfg();

        // en low for 5 cycles mid-period stretches the period by 5
        set_cfg(0, 4, 2, 1);
        bc = 0;
        ds_at = -1;
        ss_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            applyStimulus((k >= 3 && k <= 7) ? 1'b0 : 1'b1, (k == 0) ? 4'b0001 : 4'b0000, 4'b0000);
            if (busy[0]) bc++;
            if (start_strobe[0]) ss_cnt++;
            if (done_strobe[0] && ds_at < 0) ds_at = k;
        end
        check_val("enlow_busy_cycles", bc, 10);
        check_val("enlow_done_cycle", ds_at, 10);
        check_val("enlow_starts", ss_cnt, 1);

        // Asynchronous reset between edges, mid-burst
        set_cfg(0, 4, 2, 0);
        applyStimulus(1'b1, 4'b0001, 4'b0000);
        #3;
        nrst = 1'b0;
        #1;
        checkOutput("async_reset", '0, '0, '0, '0);
        #2;
        nrst = 1'b1;
        model_reset();
        ds_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 4'b0000, 4'b0000);
            if (done_strobe[0]) ds_cnt++;
        end
        check_val("reset_no_done", ds_cnt, 0);
        set_cfg(0, 4, 2, 1);
        applyStimulus(1'b1, 4'b0001, 4'b0000);
        checkOutput("restart_after_reset", 4'b0001, 4'b0001, 4'b0000, 4'b0001);
        for (int k = 0; k < 6; k++) applyStimulus(1'b1, 4'b0000, 4'b0000);
        clear_cfg();

`ifdef PULSE_GEN_MC_PHASE_EN
        // Phase offset delays only the first period
        set_cfg(0, 2, 1, 1);
        phase[0 +: CW] = 8'd3;
        bc = 0;
        pat = '0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, (k == 0) ? 4'b0001 : 4'b0000, 4'b0000);
            if (k < 6) pat[5-k] = pulse_out[0];
            if (busy[0]) bc++;
        end
        check_val("phase_pattern", int'(pat[5:0]), int'(6'b000110));
        check_val("phase_busy_cycles", bc, 6);
        phase = '0;
        clear_cfg();
`endif

        // Randomized run against the reference model
        for (int c = 0; c < CH; c++) begin
            set_cfg(c, int'($urandom_range(0, 5)), int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
        end
        for (int k = 0; k < 1500; k++) begin
            logic [CH-1:0] s;
            logic [CH-1:0] sp;
            if ($urandom_range(0, 7) == 0) begin
                int c;
                c = int'($urandom_range(0, CH - 1));
                set_cfg(c, int'($urandom_range(0, 5)), int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
`ifdef PULSE_GEN_MC_PHASE_EN
                phase[c*CW +: CW] = CW'($urandom_range(0, 3));
`endif
            end
            for (int c = 0; c < CH; c++) begin
                s[c]  = ($urandom_range(0, 3) == 0);
                sp[c] = ($urandom_range(0, 15) == 0);
            end
            applyStimulus($urandom_range(0, 9) != 0, s, sp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
